// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the register-file write path.
// Provides register/datapath widths, the mul/div result entry payload,
// the writeback grant-source encoding and a one-hot register helper.
package cpu_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

    // Buffered mul/div result: destination register plus value (37 bits)
    typedef struct packed {
        reg_addr_t rd;
        xlen_t     data;
    } wb_entry_t;

    // Which source owns the register-file write port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PIPE = 2'd1,
        GNT_MD   = 2'd2
    } gnt_src_e;

    // One-hot bit vector selecting register r
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t r);
        return NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Mul/div result buffer: small circular FIFO of {rd,data} entries.
// Ports:
//   CLK, RESET         clock, asynchronous active-low reset
//   push, push_entry   enqueue an entry (ignored when full)
//   pop                dequeue the head entry (ignored when empty)
//   head_entry_c       current head entry (valid when not empty)
//   count              registered occupancy
//   full_c, empty_c    occupancy flags decoded from count
module wb_result_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic                           push,
    input  wb_entry_t                      push_entry,
    input  logic                           pop,
    output wb_entry_t                      head_entry_c,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full_c,
    output logic                           empty_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok_c;
    logic             pop_ok_c;

    assign full_c       = (count == CNT_W'(DEPTH));
    assign empty_c      = (count == '0);
    assign push_ok_c    = push & ~full_c;
    assign pop_ok_c     = pop & ~empty_c;
    assign head_entry_c = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok_c, pop_ok_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; contents are only observed while count > 0
    always_ff @(posedge CLK) begin
        if (push_ok_c) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-side front end. Merges the in-order pipeline
// writeback stream with buffered out-of-order mul/div results onto the
// single register-file write port, prevents starvation of buffered
// results and tracks outstanding mul/div destinations for the hazard unit.
// Ports:
//   CLK, RESET                        clock, asynchronous active-low reset
//   PIPE_VALID/PIPE_RD/PIPE_DATA      pipeline writeback request
//   PIPE_STALL                        pipeline request not accepted this cycle
//   MD_ISSUE/MD_ISSUE_RD              mul/div op issued (marks rd pending)
//   MD_VALID/MD_READY/MD_RD/MD_DATA   mul/div result handshake into FIFO
//   WB_ADDRESS/WRITE_ENABLE/WRITE_DATA registered register-file write port
//   PENDING_MASK                      bit r set = mul/div result for xr outstanding
module regfile_writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PIPE_VALID,
    input  logic [REG_ADDR_W-1:0] PIPE_RD,
    input  logic [XLEN-1:0]       PIPE_DATA,
    output logic                  PIPE_STALL,
    input  logic                  MD_ISSUE,
    input  logic [REG_ADDR_W-1:0] MD_ISSUE_RD,
    input  logic                  MD_VALID,
    output logic                  MD_READY,
    input  logic [REG_ADDR_W-1:0] MD_RD,
    input  logic [XLEN-1:0]       MD_DATA,
    output logic [REG_ADDR_W-1:0] WB_ADDRESS,
    output logic                  WRITE_ENABLE,
    output logic [XLEN-1:0]       WRITE_DATA,
    output logic [NUM_REGS-1:0]   PENDING_MASK
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t           fifo_head_c;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full_c;
    logic                fifo_empty_c;
    logic                md_push_c;
    logic [STARVE_W-1:0] starve_cnt;
    logic                starve_c;
    gnt_src_e            grant_c;
    logic [NUM_REGS-1:0] pend_set_c;
    logic [NUM_REGS-1:0] pend_clr_c;

    assign MD_READY  = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign md_push_c = MD_VALID & MD_READY;
    assign starve_c  = (starve_cnt >= STARVE_W'(STARVE_LIMIT));

    wb_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK          (CLK),
        .RESET        (RESET),
        .push         (md_push_c),
        .push_entry   ('{rd: MD_RD, data: MD_DATA}),
        .pop          (grant_c == GNT_MD),
        .head_entry_c (fifo_head_c),
        .count        (fifo_count),
        .full_c       (fifo_full_c),
        .empty_c      (fifo_empty_c)
    );

    // The source is expected to hold MD_VALID while MD_READY is low
    a_no_push_when_full : assert property (
        @(posedge CLK) disable iff (!RESET) !(md_push_c && fifo_full_c)
    );

    // Single grant per cycle; a starved, non-empty FIFO preempts the pipeline
    always_comb begin
        grant_c    = GNT_NONE;
        PIPE_STALL = 1'b0;
        if (starve_c && !fifo_empty_c) begin
            grant_c = GNT_MD;
        end else if (PIPE_VALID) begin
            grant_c = GNT_PIPE;
        end else if (!fifo_empty_c) begin
            grant_c = GNT_MD;
        end
        PIPE_STALL = PIPE_VALID && (grant_c == GNT_MD);
    end

    // Counts consecutive cycles a waiting FIFO loses; saturates at the limit
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            starve_cnt <= '0;
        end else if (fifo_empty_c || grant_c == GNT_MD) begin
            starve_cnt <= '0;
        end else if (!starve_c) begin
            starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

    // Pending-destination update; rd=0 is never tracked, set beats clear
    always_comb begin
        pend_set_c = '0;
        pend_clr_c = '0;
        if (MD_ISSUE && MD_ISSUE_RD != '0) pend_set_c = reg_onehot(MD_ISSUE_RD);
        if (grant_c == GNT_MD)             pend_clr_c = reg_onehot(fifo_head_c.rd);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            PENDING_MASK <= '0;
        end else begin
            PENDING_MASK <= (PENDING_MASK & ~pend_clr_c) | pend_set_c;
        end
    end

    // Registered write port; rd=0 still updates address/data but not the strobe
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            WB_ADDRESS   <= '0;
            WRITE_DATA   <= '0;
            WRITE_ENABLE <= 1'b0;
        end else begin
            case (grant_c)
                GNT_PIPE: begin
                    WB_ADDRESS   <= PIPE_RD;
                    WRITE_DATA   <= PIPE_DATA;
                    WRITE_ENABLE <= (PIPE_RD != '0);
                end
                GNT_MD: begin
                    WB_ADDRESS   <= fifo_head_c.rd;
                    WRITE_DATA   <= fifo_head_c.data;
                    WRITE_ENABLE <= (fifo_head_c.rd != '0);
                end
                default: begin
                    WRITE_ENABLE <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: reset checks, a
// directed vector table, hand-written multi-cycle sequences and a
// randomized run compared against a queue-based reference model.
module tb_regfile_writeback_arbiter;

    localparam int FIFO_DEPTH   = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic [4:0]  wb_address;
    logic        write_enable;
    logic [31:0] write_data;
    logic [31:0] pending_mask;

    always #5 clk = ~clk;

    regfile_writeback_arbiter #(
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .CLK          (clk),
        .RESET        (rst_n),
        .PIPE_VALID   (pipe_valid),
        .PIPE_RD      (pipe_rd),
        .PIPE_DATA    (pipe_data),
        .PIPE_STALL   (pipe_stall),
        .MD_ISSUE     (md_issue),
        .MD_ISSUE_RD  (md_issue_rd),
        .MD_VALID     (md_valid),
        .MD_READY     (md_ready),
        .MD_RD        (md_rd),
        .MD_DATA      (md_data),
        .WB_ADDRESS   (wb_address),
        .WRITE_ENABLE (write_enable),
        .WRITE_DATA   (write_data),
        .PENDING_MASK (pending_mask)
    );

    // Reference model state
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } md_res_t;

    md_res_t     m_q[$];
    int          m_starve;
    logic [31:0] m_pending;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    int   tests = 0;
    int   fails = 0;
    int   last_g;      // 0 idle, 1 pipeline, 2 FIFO
    logic last_stall;
    logic last_push;

    typedef struct {
        logic        pv;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        iss;
        logic [4:0]  ird;
        logic        ewe;
        logic [4:0]  eaddr;
        logic [31:0] edata;
        logic [31:0] emask;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_starve  = 0;
        m_pending = '0;
        m_we      = 1'b0;
        m_addr    = '0;
        m_data    = '0;
        last_g    = 0;
        last_stall = 1'b0;
        last_push  = 1'b0;
    endtask

    task automatic clear_inputs();
        pipe_valid  = 1'b0;
        pipe_rd     = '0;
        pipe_data   = '0;
        md_issue    = 1'b0;
        md_issue_rd = '0;
        md_valid    = 1'b0;
        md_rd       = '0;
        md_data     = '0;
    endtask

    // Asserts reset at the current time, releases it mid-cycle, returns at posedge+1
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock with current inputs; model decides the grant from the spec rules
    task automatic cycle();
        bit      ne;
        bit      push;
        int      g;
        md_res_t head;
        @(negedge clk);
        ne = (m_q.size() != 0);
        if (m_starve >= STARVE_LIMIT && ne) g = 2;
        else if (pipe_valid)                g = 1;
        else if (ne)                        g = 2;
        else                                g = 0;
        check("md_ready", 32'(md_ready), 32'(m_q.size() < FIFO_DEPTH));
        check("pipe_stall", 32'(pipe_stall), 32'(pipe_valid && g == 2));
        last_stall = pipe_stall;
        last_g     = g;
        push       = md_valid && (m_q.size() < FIFO_DEPTH);
        last_push  = push;
        if (g == 2) m_pending[m_q[0].rd] = 1'b0;
        if (md_issue && md_issue_rd != 5'd0) m_pending[md_issue_rd] = 1'b1;
        if (g == 1) begin
            m_we = (pipe_rd != 5'd0); m_addr = pipe_rd; m_data = pipe_data;
        end else if (g == 2) begin
            head = m_q.pop_front();
            m_we = (head.rd != 5'd0); m_addr = head.rd; m_data = head.data;
        end else begin
            m_we = 1'b0;
        end
        if (!ne || g == 2) m_starve = 0;
        else if (m_starve < STARVE_LIMIT) m_starve++;
        if (push) m_q.push_back('{md_rd, md_data});
        @(posedge clk);
        #1;
        check("write_enable", 32'(write_enable), 32'(m_we));
        check("wb_address", 32'(wb_address), 32'(m_addr));
        check("write_data", write_data, m_data);
        check("pending_mask", pending_mask, m_pending);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b1, 5'd5,  32'hDEADBEEF, 32'h0000_0000};
        tbl[1] = '{1'b0, 5'd9,  32'h0000_0001, 1'b1, 5'd7,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0000_0080};
        tbl[2] = '{1'b1, 5'd0,  32'h0000_0055, 1'b1, 5'd0,  1'b0, 5'd0,  32'h0000_0055, 32'h0000_0080};
        tbl[3] = '{1'b1, 5'd31, 32'h1234_5678, 1'b1, 5'd31, 1'b1, 5'd31, 32'h1234_5678, 32'h8000_0080};
        tbl[4] = '{1'b0, 5'd3,  32'hFFFF_FFFF, 1'b0, 5'd2,  1'b0, 5'd31, 32'h1234_5678, 32'h8000_0080};
        tbl[5] = '{1'b1, 5'd1,  32'h0000_0000, 1'b1, 5'd1,  1'b1, 5'd1,  32'h0000_0000, 32'h8000_0082};

        // Reset state
        do_reset();
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_addr", 32'(wb_address), 32'd0);
        check("rst_data", write_data, 32'd0);
        check("rst_mask", pending_mask, 32'd0);
        check("rst_stall", 32'(pipe_stall), 32'd0);
        check("rst_md_ready", 32'(md_ready), 32'd1);

        // Directed vectors with an empty FIFO
        for (int i = 0; i < 6; i++) begin
            pipe_valid  = tbl[i].pv;
            pipe_rd     = tbl[i].prd;
            pipe_data   = tbl[i].pdata;
            md_issue    = tbl[i].iss;
            md_issue_rd = tbl[i].ird;
            @(negedge clk);
            check($sformatf("vec%0d_stall", i), 32'(pipe_stall), 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_we", i), 32'(write_enable), 32'(tbl[i].ewe));
            check($sformatf("vec%0d_addr", i), 32'(wb_address), 32'(tbl[i].eaddr));
            check($sformatf("vec%0d_data", i), write_data, tbl[i].edata);
            check($sformatf("vec%0d_mask", i), pending_mask, tbl[i].emask);
        end

        // Issue, buffered result, write one cycle after grant, pending cleared
        do_reset();
        md_issue = 1'b1; md_issue_rd = 5'd7;
        cycle();
        check("issue_mask", pending_mask, 32'h80);
        md_issue = 1'b0;
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h12;
        cycle();
        md_valid = 1'b0;
        cycle();
        check("md_wr_we", 32'(write_enable), 32'd1);
        check("md_wr_addr", 32'(wb_address), 32'd7);
        check("md_wr_data", write_data, 32'h12);
        check("md_wr_mask", pending_mask, 32'h0);

        // Starvation: pipeline wins four times, then the FIFO preempts
        do_reset();
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h33;
        cycle();
        md_valid = 1'b0;
        pipe_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pipe_rd = 5'(10 + i); pipe_data = 32'hB0 + 32'(i);
            cycle();
            check("starve_pipe_addr", 32'(wb_address), 32'(10 + i));
        end
        pipe_rd = 5'd20; pipe_data = 32'hCAFE;
        cycle();
        check("starve_stall", 32'(last_stall), 32'd1);
        check("starve_md_addr", 32'(wb_address), 32'd3);
        check("starve_md_data", write_data, 32'h33);
        cycle();
        check("held_pipe_addr", 32'(wb_address), 32'd20);
        check("held_pipe_data", write_data, 32'hCAFE);
        check("held_pipe_stall", 32'(last_stall), 32'd0);

        // Full FIFO back-pressure and push-order drain
        do_reset();
        pipe_valid = 1'b1; pipe_rd = 5'd15; pipe_data = 32'hA0;
        md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h44;
        cycle();
        pipe_data = 32'hA1; md_rd = 5'd6; md_data = 32'h66;
        cycle();
        check("full_md_ready", 32'(md_ready), 32'd0);
        md_rd = 5'd8; md_data = 32'h88;
        for (int i = 0; i < 3; i++) begin
            pipe_data = 32'hA2 + 32'(i);
            cycle();
            check("full_held", 32'(last_push), 32'd0);
        end
        pipe_data = 32'hA5;
        cycle();
        check("full_pop_stall", 32'(last_stall), 32'd1);
        check("full_pop_nopush", 32'(last_push), 32'd0);
        check("order_1", 32'(wb_address), 32'd4);
        cycle();
        check("third_accepted", 32'(last_push), 32'd1);
        check("held_after_stall", write_data, 32'hA5);
        pipe_valid = 1'b0; md_valid = 1'b0;
        cycle();
        check("order_2", 32'(wb_address), 32'd6);
        cycle();
        check("order_3", 32'(wb_address), 32'd8);
        check("order_3_data", write_data, 32'h88);

        // Asynchronous reset with buffered entries and pending bits
        do_reset();
        md_issue = 1'b1; md_issue_rd = 5'd8;
        pipe_valid = 1'b1; pipe_rd = 5'd12; pipe_data = 32'h1212;
        md_valid = 1'b1; md_rd = 5'd8; md_data = 32'h800;
        cycle();
        md_issue_rd = 5'd9; md_rd = 5'd9; md_data = 32'h900;
        cycle();
        md_issue = 1'b0; md_valid = 1'b0;
        check("pre_rst_mask", pending_mask, 32'h300);
        check("pre_rst_we", 32'(write_enable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_we", 32'(write_enable), 32'd0);
        check("async_addr", 32'(wb_address), 32'd0);
        check("async_data", write_data, 32'd0);
        check("async_mask", pending_mask, 32'd0);
        check("async_stall", 32'(pipe_stall), 32'd0);
        check("async_md_ready", 32'(md_ready), 32'd1);
        do_reset();
        for (int i = 0; i < 6; i++) cycle();

        // Randomized traffic against the reference model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if (last_g == 1 || !pipe_valid) begin
                pipe_valid = ($urandom_range(0, 9) < 7);
                pipe_rd    = 5'($urandom);
                pipe_data  = $urandom;
            end
            if (last_push || !md_valid) begin
                md_valid = ($urandom_range(0, 9) < 4);
                md_rd    = 5'($urandom);
                md_data  = $urandom;
            end
            md_issue    = ($urandom_range(0, 9) < 3);
            md_issue_rd = 5'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
Write-side front end of the 32x32 register file. It merges two result sources into the single register-file write port (WB_ADDRESS / WRITE_ENABLE / WRITE_DATA):
- the in-order pipeline writeback stream;
- out-of-order results from the multi-cycle RV32M mul/div unit.

Mul/div results are buffered in a small FIFO. The block prevents starvation of buffered results and exports a pending-destination mask to the hazard unit.

Parameters:
FIFO_DEPTH, 2, entries in mul/div result buffer (power of two, >=2)
STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may lose arbitration before the pipeline is stalled

Ports:
CLK  input  1  system clock; all state updates on posedge
RESET  input  1  asynchronous, active-low reset
PIPE_VALID  input  1  pipeline writeback request this cycle
PIPE_RD  input  5  pipeline destination register
PIPE_DATA  input  32  pipeline result
PIPE_STALL  output  1  pipeline write not accepted this cycle; upstream holds request
MD_ISSUE  input  1  mul/div op issued this cycle
MD_ISSUE_RD  input  5  destination of issued mul/div op
MD_VALID  input  1  mul/div result available
MD_READY  output  1  FIFO can accept result
MD_RD  input  5  mul/div result destination
MD_DATA  input  32  mul/div result
WB_ADDRESS  output  5  register-file write address
WRITE_ENABLE  output  1  register-file write strobe
WRITE_DATA  output  32  register-file write data
PENDING_MASK  output  32  bit r set = mul/div result for xr outstanding

Behaviour:
- Reset (RESET=0, asynchronous):
  - WRITE_ENABLE=0, WB_ADDRESS=0, WRITE_DATA=0.
  - PIPE_STALL=0, PENDING_MASK=0.
  - FIFO empty; starve counter=0.
- MD_READY = (fifo_count != FIFO_DEPTH), combinational from registered count; reads 1 out of reset.
- MD handshake: push on MD_VALID & MD_READY. MD_VALID while MD_READY=0 is held by the source; nothing is dropped.
- Arbitration: one grant per cycle, decided from registered state:
  - starve=1 and FIFO non-empty -> FIFO head wins; PIPE_STALL=1.
  - else PIPE_VALID=1 -> pipeline wins; PIPE_STALL=0.
  - else FIFO non-empty -> FIFO head wins.
  - else idle.
- PIPE_STALL=1 only in cycles where PIPE_VALID=1 and the FIFO wins.
- Output stage is registered, one-cycle latency: a grant at edge N drives WB_ADDRESS/WRITE_DATA/WRITE_ENABLE after edge N+1. The register file commits at edge N+2.
- rd=0 suppression:
  - A granted entry with rd=0 is consumed (FIFO popped / pipeline accepted) but WRITE_ENABLE=0.
  - WB_ADDRESS/WRITE_DATA are still updated.
- Idle cycle: WRITE_ENABLE=0; address and data hold their previous values.
- Starve counter:
  - Increments when FIFO non-empty and the pipeline wins.
  - Clears when the FIFO wins or the FIFO is empty.
  - starve = (counter >= STARVE_LIMIT); saturates at STARVE_LIMIT.
- FIFO:
  - Simultaneous push and pop: count unchanged; head advances; data ordering preserved.
  - Pop when empty is impossible by construction.
  - Pointers wrap modulo FIFO_DEPTH.
- PENDING_MASK:
  - Set bit MD_ISSUE_RD on MD_ISSUE (never bit 0).
  - Clear bit on the FIFO-head grant for that rd.
  - Set and clear of the same bit in the same cycle: set wins.
  - Mask is registered.
- RESET asserted mid-operation: FIFO contents and pending bits are discarded; no partial write is emitted.

Decomposition:
- Shared package (cpu_pkg):
  - REG_ADDR_W=5, XLEN=32, NUM_REGS=32.
  - Grant-source encoding GNT_NONE/GNT_PIPE/GNT_MD.
- One sub-module: wb_result_fifo (parameterised depth, 37-bit entries {rd,data}, count/full/empty).
- Arbiter, starve counter, pending mask and output register stay in the top.

Test Plan:
1. Reset then PIPE_VALID=1, PIPE_RD=5, PIPE_DATA=0xDEADBEEF at edge 1 -> WRITE_ENABLE=1, WB_ADDRESS=5, WRITE_DATA=0xDEADBEEF after edge 2; PIPE_STALL=0.
2. MD_ISSUE rd=7 -> PENDING_MASK=0x80. Push MD_RD=7, MD_DATA=0x12 with PIPE_VALID=0 -> write x7=0x12 one cycle after grant; PENDING_MASK returns to 0.
3. Hold PIPE_VALID=1 continuously with one FIFO entry (rd=3) -> pipeline wins 4 cycles. 5th cycle: PIPE_STALL=1, x3 written next cycle. Held pipeline write is granted the following cycle, data unchanged.
4. Push 2 results with no pops -> MD_READY=0. Third MD_VALID held 3 cycles -> accepted only after a pop. Writes emerge in push order.
5. Pipeline rd=0 with data 0x55 -> no WRITE_ENABLE pulse, PIPE_STALL=0. MD_ISSUE rd=0 -> PENDING_MASK stays 0.
6. Assert RESET with FIFO holding 2 entries and PENDING_MASK=0x300 -> all outputs 0 immediately (asynchronous), MD_READY=1. After release, no stale writes appear.
